// File: rtl/muldiv_ctrl_if.sv
// EX-stage multiply/divide bus: EX operand/control signals, the result and
// stall returned to EX, and the start/ready/annul handshake to the divider.
interface muldiv_ctrl_if;
    logic        op_valid_i;
    logic [2:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        flush_i;
    logic        pipe_stall_i;
    logic        stall_o;
    logic        result_valid_o;
    logic [63:0] result_o;
    logic        div_start_o;
    logic        div_signed_o;
    logic        div_annul_o;
    logic [31:0] div_a_o;
    logic [31:0] div_b_o;
    logic        div_ready_i;
    logic [63:0] div_result_i;

    // Pipeline and divider side.
    modport master (
        output op_valid_i, op_i, a_i, b_i, flush_i, pipe_stall_i,
        output div_ready_i, div_result_i,
        input  stall_o, result_valid_o, result_o,
        input  div_start_o, div_signed_o, div_annul_o, div_a_o, div_b_o
    );

    // Controller side.
    modport slave (
        input  op_valid_i, op_i, a_i, b_i, flush_i, pipe_stall_i,
        input  div_ready_i, div_result_i,
        output stall_o, result_valid_o, result_o,
        output div_start_o, div_signed_o, div_annul_o, div_a_o, div_b_o
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// EX-stage multiply/divide sequencer: in-house registered multiplier, external
// iterative divider handshake, EX stall and one-shot {HI,LO} result.
// Optional performance counters are built when MULDIV_PERF_CNT_EN is defined.
module muldiv_ctrl #(
    parameter int unsigned MUL_LAT     = 2,
    parameter logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_ctrl_if.slave bus
`ifdef MULDIV_PERF_CNT_EN
    ,
    output logic [31:0]  busy_cycles_o,
    output logic [15:0]  op_count_o
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [3:0] MUL_LAST = 4'(MUL_LAT - 1);

    state_t      state_q;
    state_t      state_n;
    logic [31:0] a_p0;
    logic [31:0] b_p0;
    logic [2:0]  op_p0;
    logic [3:0]  cnt_q;
    logic        first_q;
    logic        annul_q;
    logic [63:0] res_p1;
    logic [63:0] res_n;
    logic        load_res;
    logic        op_ok;
    logic        accept;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [2:0]  mul_op;

    function automatic logic [63:0] mul64(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic        sgn);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] prod;
        sa   = $signed({{32{sgn & a[31]}}, a});
        sb   = $signed({{32{sgn & b[31]}}, b});
        prod = sa * sb;
        return prod;
    endfunction

    function automatic logic is_mul(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    assign op_ok  = (bus.op_i >= OP_MULT) && (bus.op_i <= OP_DIVU);
    assign accept = !rst && (state_q == IDLE) && bus.op_valid_i && op_ok && !bus.flush_i;

    // With MUL_LAT==1 the product is taken straight from the EX operands.
    assign mul_a  = (state_q == IDLE) ? bus.a_i  : a_p0;
    assign mul_b  = (state_q == IDLE) ? bus.b_i  : b_p0;
    assign mul_op = (state_q == IDLE) ? bus.op_i : op_p0;

    always_comb begin
        state_n  = state_q;
        load_res = 1'b0;
        res_n    = mul64(mul_a, mul_b, mul_op == OP_MULT);
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!is_mul(bus.op_i)) begin
                        state_n = DIV;
                    end else if (MUL_LAT == 1) begin
                        state_n  = DONE;
                        load_res = 1'b1;
                    end else begin
                        state_n = MUL;
                    end
                end
            end
            MUL: begin
                if (bus.flush_i) begin
                    state_n = IDLE;
                end else if (cnt_q == MUL_LAST) begin
                    state_n  = DONE;
                    load_res = 1'b1;
                end
            end
            DIV: begin
                if (bus.flush_i) begin
                    state_n = IDLE;
                end else if (b_p0 == 32'd0) begin
                    state_n  = DONE;
                    load_res = 1'b1;
                    res_n    = {a_p0, DIV_ZERO_LO};
                end else if (bus.div_ready_i) begin
                    state_n  = DONE;
                    load_res = 1'b1;
                    res_n    = bus.div_result_i;
                end
            end
            DONE: begin
                // A stalled DONE keeps the same instruction in EX; it must not restart.
                if (bus.flush_i || !bus.pipe_stall_i) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // p0: operand latch and sequencing control
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_p0    <= '0;
            b_p0    <= '0;
            op_p0   <= '0;
            cnt_q   <= '0;
            first_q <= 1'b0;
            annul_q <= 1'b0;
        end else begin
            state_q <= state_n;
            annul_q <= (state_q == DIV) && bus.flush_i;
            if (accept) begin
                a_p0    <= bus.a_i;
                b_p0    <= bus.b_i;
                op_p0   <= bus.op_i;
                cnt_q   <= 4'd1;
                first_q <= 1'b1;
            end else begin
                if (state_q == MUL) begin
                    cnt_q <= cnt_q + 4'd1;
                end
                if (state_q == DIV) begin
                    first_q <= 1'b0;
                end
            end
        end
    end

    // p1: {HI,LO} result register
    always_ff @(posedge clk) begin
        if (rst) begin
            res_p1 <= '0;
        end else if (load_res) begin
            res_p1 <= res_n;
        end
    end

    assign bus.stall_o        = accept || (state_q == MUL) || (state_q == DIV);
    assign bus.result_valid_o = (state_q == DONE) && !bus.flush_i;
    assign bus.result_o       = res_p1;
    assign bus.div_start_o    = (state_q == DIV) && first_q && (b_p0 != 32'd0);
    assign bus.div_signed_o   = (state_q == DIV) && (op_p0 == OP_DIV);
    assign bus.div_annul_o    = annul_q;
    assign bus.div_a_o        = a_p0;
    assign bus.div_b_o        = b_p0;

`ifdef MULDIV_PERF_CNT_EN
    logic done_first_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_cycles_o <= '0;
            op_count_o    <= '0;
            done_first_q  <= 1'b0;
        end else begin
            done_first_q <= (state_n == DONE) && (state_q != DONE);
            if (bus.stall_o) begin
                busy_cycles_o <= busy_cycles_o + 32'd1;
            end
            if ((state_q == DONE) && done_first_q && !bus.flush_i) begin
                op_count_o <= op_count_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed plus randomized bench for muldiv_ctrl with a behavioural divider
// and an arithmetic reference for {HI,LO}.
module tb_muldiv_ctrl;
    localparam int unsigned MUL_LAT = 2;

    logic clk = 1'b0;
    logic rst;
    muldiv_ctrl_if bus ();

`ifdef MULDIV_PERF_CNT_EN
    logic [31:0] busy_cycles;
    logic [15:0] op_count;
    int          exp_ops = 0;
`endif

    muldiv_ctrl #(
        .MUL_LAT    (MUL_LAT),
        .DIV_ZERO_LO(32'hFFFF_FFFF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef MULDIV_PERF_CNT_EN
        ,
        .busy_cycles_o(busy_cycles),
        .op_count_o   (op_count)
`endif
    );

    always #5 clk = ~clk;

    int nvec  = 0;
    int nfail = 0;

    // Behavioural divider: ready in the dly-th cycle after the start cycle.
    int          div_dly = 4;
    logic        mdl_ready = 1'b0;
    logic        inj_ready = 1'b0;
    logic [63:0] mdl_result = '0;
    int          mdl_cnt = 0;
    bit          mdl_busy = 0;

    assign bus.div_ready_i  = mdl_ready | inj_ready;
    assign bus.div_result_i = mdl_result;

    function automatic logic [63:0] div_ref(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sp;
        logic [63:0] up;
        case (op)
            3'd1: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                return sp;
            end
            3'd2: begin
                up = {32'd0, a} * {32'd0, b};
                return up;
            end
            default: return (b == 32'd0) ? {a, 32'hFFFF_FFFF} : div_ref(a, b, op == 3'd3);
        endcase
    endfunction

    function automatic int stall_ref(input logic [2:0] op, input logic [31:0] b, input int dly);
        if (op <= 3'd2) return MUL_LAT;
        if (b == 32'd0) return 2;
        return dly + 2;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            mdl_busy  = 0;
            mdl_ready = 1'b0;
        end else begin
            mdl_ready = 1'b0;
            if (bus.div_annul_o) begin
                mdl_busy = 0;
            end else if (mdl_busy) begin
                mdl_cnt--;
                if (mdl_cnt == 0) begin
                    mdl_ready = 1'b1;
                    mdl_busy  = 0;
                end
            end
            if (bus.div_start_o) begin
                mdl_busy   = 1;
                mdl_cnt    = div_dly;
                mdl_result = div_ref(bus.div_a_o, bus.div_b_o, bus.div_signed_o);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag);
        tick();
        bus.op_valid_i   = 1'b0;
        bus.pipe_stall_i = 1'b0;
        #1;
        chk({tag, ".idle_stall"}, bus.stall_o, 0);
        chk({tag, ".idle_valid"}, bus.result_valid_o, 0);
    endtask

    // Issues one instruction and follows it through DONE (and a held DONE).
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int dly, input int hold,
                          input logic [63:0] exp_res, input int exp_stall);
        int n_stall = 0;
        int n_start = 0;
        bit seen    = 0;
        tick();
        div_dly          = dly;
        bus.op_valid_i   = 1'b1;
        bus.op_i         = op;
        bus.a_i          = a;
        bus.b_i          = b;
        bus.flush_i      = 1'b0;
        bus.pipe_stall_i = 1'b0;
        #1;
        chk({tag, ".accept_stall"}, bus.stall_o, 1);
        for (int c = 0; c < 300; c++) begin
            if (bus.stall_o) n_stall++;
            if (bus.div_start_o) begin
                n_start++;
                chk({tag, ".div_signed"}, bus.div_signed_o, op == 3'd3);
                chk({tag, ".div_a"}, bus.div_a_o, a);
                chk({tag, ".div_b"}, bus.div_b_o, b);
            end
            if (bus.result_valid_o) begin
                seen = 1;
                break;
            end
            @(posedge clk);
            #2;
        end
        chk({tag, ".done_seen"}, seen, 1);
        chk({tag, ".result"}, bus.result_o, exp_res);
        chk({tag, ".done_stall"}, bus.stall_o, 0);
        chk({tag, ".stall_cycles"}, n_stall, exp_stall);
        chk({tag, ".starts"}, n_start, (op >= 3'd3 && b != 32'd0) ? 1 : 0);
`ifdef MULDIV_PERF_CNT_EN
        exp_ops++;
`endif
        if (hold > 0) begin
            bus.pipe_stall_i = 1'b1;
            for (int h = 0; h < hold; h++) begin
                @(posedge clk);
                #2;
                chk({tag, ".hold_valid"}, bus.result_valid_o, 1);
                chk({tag, ".hold_result"}, bus.result_o, exp_res);
                chk({tag, ".hold_start"}, bus.div_start_o, 0);
                chk({tag, ".hold_stall"}, bus.stall_o, 0);
                if (h == hold - 1) bus.pipe_stall_i = 1'b0;
            end
        end
    endtask

    // Starts a DIV and flushes it in cycle 5 counted from the accept cycle.
    task automatic flush_div(input string tag, input int dly);
        tick();
        div_dly        = dly;
        bus.op_valid_i = 1'b1;
        bus.op_i       = 3'd3;
        bus.a_i        = 32'hFFFF_FF9C;
        bus.b_i        = 32'd7;
        #1;
        chk({tag, ".accept_stall"}, bus.stall_o, 1);
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk);
            #2;
            chk({tag, ".valid_before"}, bus.result_valid_o, 0);
            if (c == 1) chk({tag, ".start"}, bus.div_start_o, 1);
        end
        bus.flush_i = 1'b1;
        #1;
        chk({tag, ".flush_valid"}, bus.result_valid_o, 0);
        tick();
        bus.flush_i    = 1'b0;
        bus.op_valid_i = 1'b0;
        #1;
        chk({tag, ".annul"}, bus.div_annul_o, 1);
        chk({tag, ".after_stall"}, bus.stall_o, 0);
        chk({tag, ".after_valid"}, bus.result_valid_o, 0);
        tick();
        #1;
        chk({tag, ".annul_once"}, bus.div_annul_o, 0);
        inj_ready = 1'b1;
        tick();
        inj_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk({tag, ".late_ready_valid"}, bus.result_valid_o, 0);
            chk({tag, ".late_ready_stall"}, bus.stall_o, 0);
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        int          rdly, rhold;

        rst              = 1'b1;
        bus.op_valid_i   = 1'b0;
        bus.op_i         = '0;
        bus.a_i          = '0;
        bus.b_i          = '0;
        bus.flush_i      = 1'b0;
        bus.pipe_stall_i = 1'b0;

        repeat (2) tick();
        #1;
        chk("reset.stall", bus.stall_o, 0);
        chk("reset.valid", bus.result_valid_o, 0);
        chk("reset.result", bus.result_o, 0);
        chk("reset.start", bus.div_start_o, 0);
        chk("reset.annul", bus.div_annul_o, 0);
        chk("reset.div_a", bus.div_a_o, 0);
        chk("reset.signed", bus.div_signed_o, 0);
        tick();
        rst = 1'b0;

        run_op("mult", 3'd1, 32'hFFFF_FFFE, 32'd3, 4, 0, 64'hFFFF_FFFF_FFFF_FFFA, MUL_LAT);
        idle("mult");
        run_op("multu", 3'd2, 32'hFFFF_FFFE, 32'd3, 4, 0, 64'h0000_0002_FFFF_FFFA, MUL_LAT);
        idle("multu");
        // Ready arrives in the 34th cycle counting the start cycle.
        run_op("div", 3'd3, 32'hFFFF_FFF9, 32'd2, 33, 0, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 35);
        idle("div");
        run_op("divu0", 3'd4, 32'd10, 32'd0, 4, 0, {32'd10, 32'hFFFF_FFFF}, 2);
        idle("divu0");
        run_op("hold", 3'd4, 32'd100, 32'd7, 5, 3, {32'd2, 32'd14}, 7);
        idle("hold");

        run_op("b2b_mult", 3'd1, 32'd12345, 32'hFFFF_FFF0, 4, 0, ref_result(3'd1, 32'd12345, 32'hFFFF_FFF0), MUL_LAT);
        run_op("b2b_divu", 3'd4, 32'hF000_0000, 32'd9, 6, 0, ref_result(3'd4, 32'hF000_0000, 32'd9), 8);
        idle("b2b");

        flush_div("flush", 33);
        flush_div("flush_ready", 4);

        tick();
        bus.op_valid_i = 1'b1;
        bus.op_i       = 3'd1;
        bus.flush_i    = 1'b1;
        #1;
        chk("flush_idle.stall", bus.stall_o, 0);
        tick();
        bus.flush_i = 1'b0;
        bus.op_i    = 3'd5;
        #1;
        chk("bad_op.stall", bus.stall_o, 0);
        tick();
        bus.op_valid_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("flush_idle.valid", bus.result_valid_o, 0);
            chk("flush_idle.stall_after", bus.stall_o, 0);
            tick();
        end

        run_op("flush_done", 3'd2, 32'd7, 32'd6, 4, 0, 64'd42, MUL_LAT);
        bus.flush_i = 1'b1;
        #1;
        chk("flush_done.valid", bus.result_valid_o, 0);
`ifdef MULDIV_PERF_CNT_EN
        exp_ops--;
`endif
        tick();
        bus.flush_i    = 1'b0;
        bus.op_valid_i = 1'b0;
        #1;
        chk("flush_done.idle_valid", bus.result_valid_o, 0);
        chk("flush_done.idle_stall", bus.stall_o, 0);

        tick();
        div_dly        = 20;
        bus.op_valid_i = 1'b1;
        bus.op_i       = 3'd3;
        bus.a_i        = 32'd5;
        bus.b_i        = 32'd1;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst            = 1'b0;
        bus.op_valid_i = 1'b0;
        #1;
        chk("rst_mid.stall", bus.stall_o, 0);
        chk("rst_mid.valid", bus.result_valid_o, 0);
        chk("rst_mid.div_a", bus.div_a_o, 0);
        chk("rst_mid.div_b", bus.div_b_o, 0);
        chk("rst_mid.result", bus.result_o, 0);
        chk("rst_mid.signed", bus.div_signed_o, 0);
        chk("rst_mid.annul", bus.div_annul_o, 0);
`ifdef MULDIV_PERF_CNT_EN
        exp_ops = 0;
`endif
        for (int c = 0; c < 25; c++) begin
            tick();
            #1;
            if (c % 8 == 0) chk("rst_mid.no_result", bus.result_valid_o, 0);
        end

        for (int i = 0; i < 24; i++) begin
            rop  = 3'($urandom_range(1, 4));
            ra   = $urandom;
            rb   = $urandom;
            case ($urandom_range(0, 4))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 9));
                2: ra = 32'($urandom_range(0, 255));
                default: ;
            endcase
            rdly  = $urandom_range(1, 12);
            rhold = $urandom_range(0, 2);
            run_op("rand", rop, ra, rb, rdly, rhold, ref_result(rop, ra, rb), stall_ref(rop, rb, rdly));
            if ($urandom_range(0, 1) == 1) idle("rand");
        end
        idle("final");

`ifdef MULDIV_PERF_CNT_EN
        chk("perf.op_count", op_count, exp_ops);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
